// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// fft_pkg : shared FFT widths, radix codes and stage-sequencer state encoding
// Rev 1.0 : initial release
// ============================================================================
package fft_pkg;

  localparam int POINTS_W   = 11;
  localparam int STAGE_W    = 5;
  localparam int RADIX_W    = 3;
  localparam int MAX_POINTS = 1200;

  localparam logic [RADIX_W-1:0] R2 = 3'd2;
  localparam logic [RADIX_W-1:0] R3 = 3'd3;
  localparam logic [RADIX_W-1:0] R5 = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_CMP   = 3'd2,
    S_RUN   = 3'd3,
    S_FIN   = 3'd4
  } seq_state_t;

  // Global stage order is all radix-5 stages, then radix-3, then radix-2.
  function automatic logic [RADIX_W-1:0] radix_of(input logic [STAGE_W-1:0] idx,
                                                  input logic [2:0]         s3,
                                                  input logic [1:0]         s5);
    logic [STAGE_W-1:0] w_n5;
    logic [STAGE_W-1:0] w_n53;
    w_n5  = {3'b000, s5};
    w_n53 = w_n5 + {2'b00, s3};
    if (idx < w_n5)  return R5;
    if (idx < w_n53) return R3;
    return R2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_stage_sequencer_if.sv
`default_nettype none
// ============================================================================
// fft_stage_sequencer_if : butterfly job bus between sequencer and engine
// Rev 1.0 : initial release
// ============================================================================
interface fft_stage_sequencer_if;

  logic                          bf_valid;
  logic                          bf_ready;
  logic [fft_pkg::STAGE_W-1:0]   bf_stage;
  logic [fft_pkg::RADIX_W-1:0]   bf_radix;
  logic [fft_pkg::POINTS_W-1:0]  bf_span;
  logic [fft_pkg::POINTS_W-1:0]  bf_base;
  logic                          bf_first;

  modport master (
    output bf_valid, bf_stage, bf_radix, bf_span, bf_base, bf_first,
    input  bf_ready
  );

  modport slave (
    input  bf_valid, bf_stage, bf_radix, bf_span, bf_base, bf_first,
    output bf_ready
  );

endinterface
`default_nettype wire

// File: rtl/fft_stage_sequencer_radix_mul.sv
`default_nettype none
// ============================================================================
// radix_mul : combinational x2/x3/x5 shift-add multiplier with overflow flag
// Rev 1.0 : initial release
// ============================================================================
module radix_mul
  import fft_pkg::*;
(
  input  logic [11:0]        a,
  input  logic [RADIX_W-1:0] radix,
  output logic [11:0]        y,
  output logic               ovf
);

  logic [14:0] w_a;
  logic [14:0] w_full;

  always_comb begin
    w_a = {3'b000, a};
    case (radix)
      R2:      w_full = w_a << 1;
      R3:      w_full = (w_a << 1) + w_a;
      R5:      w_full = (w_a << 2) + w_a;
      default: w_full = w_a;
    endcase
    y   = w_full[11:0];
    ovf = (w_full > 15'd2047);
  end

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// fft_stage_sequencer : validates a mixed-radix stage split, then streams jobs
// Rev 1.0 : initial release
// ============================================================================
module fft_stage_sequencer
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          stages2,
  input  logic [2:0]          stages3,
  input  logic [1:0]          stages5,
  input  logic [POINTS_W-1:0] points,
  output logic                busy,
  output logic                done,
  output logic                err,
  fft_stage_sequencer_if.master bf
);

  seq_state_t          r_state, w_state_nxt;
  logic [3:0]          r_s2, w_s2_nxt;
  logic [2:0]          r_s3, w_s3_nxt;
  logic [1:0]          r_s5, w_s5_nxt;
  logic [POINTS_W-1:0] r_points, w_points_nxt;
  logic [11:0]         r_prod, w_prod_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic [STAGE_W-1:0]  r_idx, w_idx_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_valid, w_valid_nxt;
  logic [STAGE_W-1:0]  r_stage, w_stage_nxt;
  logic [RADIX_W-1:0]  r_radix, w_radix_nxt;
  logic [POINTS_W-1:0] r_span, w_span_nxt;
  logic [POINTS_W-1:0] r_base, w_base_nxt;
  logic                r_first, w_first_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;

  logic [STAGE_W-1:0]  w_total;
  logic [11:0]         w_base_sum;
  logic [11:0]         w_mul_a;
  logic [RADIX_W-1:0]  w_mul_radix;
  logic [11:0]         w_mul_y;
  logic                w_mul_ovf;

  // One multiplier serves both the CHECK product and the RUN span update.
  radix_mul u_radix_mul (
    .a     (w_mul_a),
    .radix (w_mul_radix),
    .y     (w_mul_y),
    .ovf   (w_mul_ovf)
  );

  assign w_total    = {1'b0, r_s2} + {2'b00, r_s3} + {3'b000, r_s5};
  assign w_base_sum = {1'b0, r_base} + {9'd0, r_radix};

  always_comb begin
    w_state_nxt  = r_state;
    w_s2_nxt     = r_s2;
    w_s3_nxt     = r_s3;
    w_s5_nxt     = r_s5;
    w_points_nxt = r_points;
    w_prod_nxt   = r_prod;
    w_ovf_nxt    = r_ovf;
    w_idx_nxt    = r_idx;
    w_busy_nxt   = r_busy;
    w_valid_nxt  = r_valid;
    w_stage_nxt  = r_stage;
    w_radix_nxt  = r_radix;
    w_span_nxt   = r_span;
    w_base_nxt   = r_base;
    w_first_nxt  = r_first;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_mul_a      = r_prod;
    w_mul_radix  = radix_of(r_idx, r_s3, r_s5);

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (stages2 == 4'd0 && stages3 == 3'd0 && stages5 == 2'd0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_s2_nxt     = stages2;
            w_s3_nxt     = stages3;
            w_s5_nxt     = stages5;
            w_points_nxt = points;
            w_prod_nxt   = 12'd1;
            w_ovf_nxt    = 1'b0;
            w_idx_nxt    = '0;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        w_prod_nxt = w_mul_y;
        w_ovf_nxt  = r_ovf | w_mul_ovf;
        w_idx_nxt  = r_idx + 5'd1;
        if (r_idx == w_total - 5'd1) w_state_nxt = S_CMP;
      end
      S_CMP: begin
        if (r_ovf || (r_prod != {1'b0, r_points})) begin
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_span_nxt  = 11'd1;
          w_base_nxt  = '0;
          w_stage_nxt = '0;
          w_radix_nxt = radix_of('0, r_s3, r_s5);
          w_first_nxt = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_mul_a     = {1'b0, r_span};
        w_mul_radix = r_radix;
        if (bf.bf_ready) begin
          if (w_base_sum == {1'b0, r_points}) begin
            if (r_stage == w_total - 5'd1) begin
              w_valid_nxt = 1'b0;
              w_first_nxt = 1'b0;
              w_state_nxt = S_FIN;
            end else begin
              w_span_nxt  = w_mul_y[POINTS_W-1:0];
              w_base_nxt  = '0;
              w_stage_nxt = r_stage + 5'd1;
              w_radix_nxt = radix_of(r_stage + 5'd1, r_s3, r_s5);
              w_first_nxt = 1'b1;
            end
          end else begin
            w_base_nxt  = w_base_sum[POINTS_W-1:0];
            w_first_nxt = 1'b0;
          end
        end
      end
      S_FIN: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_s2     <= '0;
      r_s3     <= '0;
      r_s5     <= '0;
      r_points <= '0;
      r_prod   <= 12'd1;
      r_ovf    <= 1'b0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_stage  <= '0;
      r_radix  <= '0;
      r_span   <= '0;
      r_base   <= '0;
      r_first  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_s2     <= w_s2_nxt;
      r_s3     <= w_s3_nxt;
      r_s5     <= w_s5_nxt;
      r_points <= w_points_nxt;
      r_prod   <= w_prod_nxt;
      r_ovf    <= w_ovf_nxt;
      r_idx    <= w_idx_nxt;
      r_busy   <= w_busy_nxt;
      r_valid  <= w_valid_nxt;
      r_stage  <= w_stage_nxt;
      r_radix  <= w_radix_nxt;
      r_span   <= w_span_nxt;
      r_base   <= w_base_nxt;
      r_first  <= w_first_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign bf.bf_valid = r_valid;
  assign bf.bf_stage = r_stage;
  assign bf.bf_radix = r_radix;
  assign bf.bf_span  = r_span;
  assign bf.bf_base  = r_base;
  assign bf.bf_first = r_first;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fft_stage_sequencer : directed self-checking bench for the stage sequencer
// Rev 1.0 : initial release
// ============================================================================
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  stages2 = '0;
  logic [2:0]  stages3 = '0;
  logic [1:0]  stages5 = '0;
  logic [10:0] points = '0;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  // Expected job word: {stage[4:0], radix[2:0], span[10:0], base[10:0], first}
  logic [30:0] exp_q[$];

  fft_stage_sequencer_if bf ();

  fft_stage_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stages2 (stages2),
    .stages3 (stages3),
    .stages5 (stages5),
    .points  (points),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bf      (bf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input int pts, input int s2, input int s3, input int s5);
    int rads[$];
    int stage;
    int span;
    logic [30:0] job;
    exp_q.delete();
    repeat (s5) rads.push_back(5);
    repeat (s3) rads.push_back(3);
    repeat (s2) rads.push_back(2);
    stage = 0;
    span  = 1;
    foreach (rads[i]) begin
      int r;
      r = rads[i];
      for (int b = 0; b < pts; b += r) begin
        job = {stage[4:0], r[2:0], span[10:0], b[10:0], (b == 0)};
        exp_q.push_back(job);
      end
      span  = span * r;
      stage = stage + 1;
    end
  endtask

  task automatic run(input string tag, input int pts, input int s2, input int s3, input int s5,
                     input bit rnd, input bit spam, input int exp_jobs, input int exp_lat);
    int cyc = 0;
    int nacc = 0;
    int nfirst = 0;
    int first_cyc = -1;
    int errs_seen = 0;
    bit seen_done = 1'b0;
    bit rdy;
    logic [30:0] want;
    build(pts, s2, s3, s5);
    @(negedge clk);
    points     = pts[10:0];
    stages2    = s2[3:0];
    stages3    = s3[2:0];
    stages5    = s5[1:0];
    start      = 1'b1;
    bf.bf_ready = 1'b1;
    while (!seen_done && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) check({tag, "_busy_c1"}, 32'(busy), 32'd1);
      if (err) errs_seen++;
      rdy = 1'b1;
      if (bf.bf_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (rnd) rdy = 1'($urandom_range(0, 1));
        want = (exp_q.size() == 0) ? 31'h7fffffff : exp_q[0];
        check({tag, "_job"}, 32'({bf.bf_stage, bf.bf_radix, bf.bf_span, bf.bf_base, bf.bf_first}),
              32'(want));
        if (rdy) begin
          nacc++;
          if (bf.bf_first) nfirst++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      bf.bf_ready = rdy;
      if (done) begin
        seen_done = 1'b1;
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      end
      start = spam && busy && !done && (cyc % 5 == 2);
    end
    start = 1'b0;
    bf.bf_ready = 1'b1;
    check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    check({tag, "_jobs"}, 32'(nacc), 32'(exp_jobs));
    check({tag, "_first_count"}, 32'(nfirst), 32'(s2 + s3 + s5));
    check({tag, "_no_err"}, 32'(errs_seen), 32'd0);
    if (exp_lat > 0) begin
      check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, "_first_valid_cyc"}, 32'(first_cyc), 32'(s2 + s3 + s5 + 2));
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
  endtask

  task automatic run_err(input string tag, input int pts, input int s2, input int s3, input int s5,
                         input int exp_cyc);
    int cyc = 0;
    int err_cyc = -1;
    int vseen = 0;
    logic busy_at_err = 1'b1;
    @(negedge clk);
    points  = pts[10:0];
    stages2 = s2[3:0];
    stages3 = s3[2:0];
    stages5 = s5[1:0];
    start   = 1'b1;
    while (err_cyc < 0 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (bf.bf_valid) vseen++;
      if (err) begin
        err_cyc     = cyc;
        busy_at_err = busy;
      end
    end
    check({tag, "_err_cyc"}, 32'(err_cyc), 32'(exp_cyc));
    check({tag, "_no_valid"}, 32'(vseen), 32'd0);
    check({tag, "_busy_at_err"}, 32'(busy_at_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_err_pulse"}, 32'({err, busy}), 32'd0);
  endtask

  initial begin
    bit found;
    bf.bf_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ctl", 32'({busy, done, err, bf.bf_valid, bf.bf_first}), 32'd0);
    check("reset_bus", 32'({bf.bf_stage, bf.bf_radix, bf.bf_span, bf.bf_base}), 32'd0);
    reset = 1'b0;

    // 12 = 3*2*2 : 4 + 6 + 6 jobs, 3 check cycles
    run("p12", 12, 2, 1, 0, 1'b0, 1'b0, 16, 22);
    // 60 = 5*3*2*2 : 12 + 20 + 30 + 30 jobs, 4 check cycles
    run("p60", 60, 2, 1, 1, 1'b0, 1'b0, 92, 99);
    run_err("p24_mismatch", 24, 2, 1, 0, 5);
    run_err("ovf", 1200, 15, 7, 3, 27);
    run_err("all_zero", 12, 0, 0, 0, 1);
    run("p12_rnd", 12, 2, 1, 0, 1'b1, 1'b0, 16, 0);

    // Reset while the second stage is running
    @(negedge clk);
    points  = 11'd12;
    stages2 = 4'd2;
    stages3 = 3'd1;
    stages5 = 2'd0;
    start   = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (bf.bf_valid && bf.bf_stage == 5'd1) found = 1'b1;
    end
    check("rst_reached_stage1", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_ctl", 32'({busy, done, err, bf.bf_valid, bf.bf_first}), 32'd0);
    check("rst_mid_bus", 32'({bf.bf_stage, bf.bf_radix, bf.bf_span, bf.bf_base}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_resume", 32'({busy, bf.bf_valid, done, err}), 32'd0);

    // 36 = 3*3*2*2 : 12 + 12 + 18 + 18 jobs, start pulses while busy
    run("p36_spam", 36, 2, 2, 0, 1'b0, 1'b1, 60, 67);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
